// File: rtl/bitonic_sort_pipe.sv
// bitonic_sort_pipe
//   Pipelined bitonic sorter with a valid/ready stream interface. Each
//   compare-exchange layer of the network is followed by one register
//   stage, so a full vector is accepted every cycle. The whole pipeline
//   advances together and holds together under backpressure.
//
// Parameters
//   WIDTH  bits per element (unsigned), >= 1
//   LOG_N  lane count N = 2**LOG_N, 1..5
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_data    in   N*WIDTH  input vector, lane i = in_data[i*WIDTH +: WIDTH]
//   in_desc    in   1  direction for this beat (0 ascending, 1 descending)
//   in_valid   in   1  input beat present
//   in_ready   out  1  sorter accepts a beat this cycle
//   out_data   out  N*WIDTH  sorted vector, same lane packing
//   out_desc   out  1  direction bit that travelled with the beat
//   out_valid  out  1  out_data holds a sorted beat
//   out_ready  in   1  consumer accepts the beat
module bitonic_sort_pipe #(
  parameter int WIDTH = 4,
  parameter int LOG_N = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [(1<<LOG_N)*WIDTH-1:0] in_data,
  input  logic                      in_desc,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [(1<<LOG_N)*WIDTH-1:0] out_data,
  output logic                      out_desc,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int N  = 1 << LOG_N;
  localparam int S  = LOG_N * (LOG_N + 1) / 2;
  localparam int DW = N * WIDTH;

  // Stage k enumerates the network layers in order: merge phase p runs
  // from 0 to LOG_N-1, and within it the exchange distance 2**q shrinks
  // from 2**p down to 1.
  function automatic int stage_merge(input int k);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 0; p < LOG_N; p++) begin
      for (int q = p; q >= 0; q--) begin
        if (cnt == k) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic int stage_dist(input int k);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 0; p < LOG_N; p++) begin
      for (int q = p; q >= 0; q--) begin
        if (cnt == k) res = q;
        cnt++;
      end
    end
    return res;
  endfunction

  logic [DW-1:0] r_data [S];
  logic [S-1:0]  r_desc;
  logic [S-1:0]  r_valid;

  logic [DW-1:0] w_src [S];
  logic [DW-1:0] w_cx  [S];
  logic [S-1:0]  w_src_desc;
  logic [S-1:0]  w_src_valid;
  logic          w_adv;

  // Global advance: the pipeline moves whenever the output slot is empty
  // or is being drained. No dependency on in_valid.
  assign w_adv    = !r_valid[S-1] | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int P = stage_merge(k);
    localparam int Q = stage_dist(k);

    if (k == 0) begin : g_head
      assign w_src[k]       = in_data;
      assign w_src_desc[k]  = in_desc;
      assign w_src_valid[k] = in_valid;
    end else begin : g_body
      assign w_src[k]       = r_data[k-1];
      assign w_src_desc[k]  = r_desc[k-1];
      assign w_src_valid[k] = r_valid[k-1];
    end

    // Every lane belongs to exactly one pair (i, i^2**Q); the lower index
    // of the pair drives both output lanes.
    for (genvar i = 0; i < N; i++) begin : g_lane
      localparam int J = i ^ (1 << Q);
      if (i < J) begin : g_cmp
        // Within merge phase P, blocks of size 2**(P+1) alternate
        // direction; bit P+1 of the lane index selects which.
        localparam bit UP = (((i >> (P + 1)) & 1) == 0);
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic             w_asc;
        logic             w_swap;

        assign w_a    = w_src[k][i*WIDTH +: WIDTH];
        assign w_b    = w_src[k][J*WIDTH +: WIDTH];
        // A descending beat flips every comparator in the layer.
        assign w_asc  = UP ^ w_src_desc[k];
        assign w_swap = w_asc ? (w_a > w_b) : (w_a < w_b);

        assign w_cx[k][i*WIDTH +: WIDTH] = w_swap ? w_b : w_a;
        assign w_cx[k][J*WIDTH +: WIDTH] = w_swap ? w_a : w_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < S; k++) begin
        r_data[k] <= '0;
      end
      r_desc  <= '0;
      r_valid <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < S; k++) begin
        r_data[k] <= w_cx[k];
      end
      r_desc  <= w_src_desc;
      r_valid <= w_src_valid;
    end
  end

  assign out_data  = r_data[S-1];
  assign out_desc  = r_desc[S-1];
  assign out_valid = r_valid[S-1];

endmodule

// File: doc/bitonic_sort_pipe.md
# bitonic_sort_pipe

Pipelined, parametrised bitonic sorter with a valid/ready stream interface. Successor to the fixed 8-lane, 4-bit combinational sorter: lane count, element width and sort direction are configurable, and one compare-exchange stage is registered per clock so one full vector is accepted every cycle. Sits between a vector producer and consumer on a single clock domain. Stalls cleanly under backpressure.

## Interface
- WIDTH, 4: bits per element, unsigned, ≥1.
- LOG_N, 3: lane count N = 2^LOG_N, 1..5.
- Derived S = LOG_N*(LOG_N+1)/2: number of compare-exchange stages. For N=8, S=6.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  N*WIDTH  input vector; lane i = in_data[i*WIDTH +: WIDTH].
- in_desc  in  1  direction for this beat: 0 ascending, 1 descending.
- in_valid  in  1  input beat present.
- in_ready  out  1  sorter can accept a beat this cycle.
- out_data  out  N*WIDTH  sorted vector, same lane packing.
- out_desc  out  1  direction bit that travelled with the beat.
- out_valid  out  1  out_data holds a sorted beat.
- out_ready  in  1  consumer accepts the beat.

## Operation
- Pipeline has S register stages. Each stage holds: data N*WIDTH, desc 1, valid 1.
- Stage k implements one layer of the standard bitonic network: merge size 2^(p+1), distance 2^q.
- Comparator on lanes (i, i^2^q), i < partner, is unsigned. Ascending compare-exchange puts the smaller value on lane i when bit (p+1) of i is 0, otherwise the larger value.
- A stage's desc bit inverts every comparator direction in that stage. The whole vector is therefore sorted descending.
- Final ordering:
  - ascending: lane 0 holds the minimum, lane N-1 the maximum.
  - descending: the reverse.
  - Equal values keep no identity; only the multiset is preserved.
- Advance condition: adv = !out_valid | out_ready.
- When adv=1, every stage loads from its predecessor; stage 0 loads in_data, in_desc and in_valid.
- When adv=0, all stages hold (global stall). Bubbles are not compressed.
- in_ready = adv. This is combinational from out_valid/out_ready, with no path from in_valid.
- A beat is accepted iff in_valid & in_ready. A beat is delivered iff out_valid & out_ready.
- Data registers of stages whose valid bit is 0 are don't-care. out_data is only meaningful when out_valid=1.
- Degenerate case LOG_N=0 is not supported. LOG_N=1 gives S=1, a single comparator.

## Timing
- Reset (reset=0, asynchronous assert, synchronous-to-clk deassert at the source): all stage valid bits clear, so out_valid=0.
  - Data and desc registers reset to 0, so out_data=0 and out_desc=0.
  - in_ready is 1 during and after reset, because out_valid=0.
- Latency: a beat accepted on edge t appears with out_valid=1 after edge t+S-1, i.e. S cycles of registers. For N=8 this is 6 edges.
- Throughput: one beat per cycle when out_ready is held at 1.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data and out_desc are stable and in_ready=0.
  - No beat is lost or duplicated.
  - While the pipeline is stalled, in_valid and in_data may change freely; they are not captured.
- Simultaneous delivery and acceptance in the same cycle is permitted; the pipeline shifts by one.
- Reset asserted mid-stream: all in-flight beats are discarded immediately (out_valid falls asynchronously). There is no partial output after deassert.

## Test plan
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=1 throughout; nothing emerges 6 cycles after release unless driven.
- Ascending, N=8, W=4:
  - stimulus: lanes 0..7 = 3,7,0,15,9,9,1,4; in_desc=0; out_ready=1.
  - response: out_valid exactly 6 cycles later; lanes 0..7 = 0,1,3,4,7,9,9,15; out_desc=0.
- Descending, same vector with in_desc=1 -> lanes 0..7 = 15,9,9,7,4,3,1,0; out_desc=1.
- Back-to-back direction mix:
  - stimulus: 16 consecutive beats, random values, alternating in_desc, out_ready=1.
  - response: 16 consecutive out_valid cycles, each correctly sorted per its own desc; in_ready=1 every cycle.
- Backpressure:
  - stimulus: stream 10 beats, drive out_ready=0 for 4 cycles when the first beat emerges, then randomise out_ready.
  - response: out_data held stable while stalled; in_ready=0 during the stall; all 10 beats delivered in order, none dropped or duplicated.
- Reset mid-stream: pull reset low with 3 beats in flight -> out_valid=0 immediately; after release, the next beat accepted emerges alone after 6 cycles. Additionally, rerun the sort checks with WIDTH=8, LOG_N=4 (S=10) against a reference sort.
